// File: rtl/timer_controller_pkg.sv
// Shared encodings and limits for the countdown-timer core.
package timer_controller_pkg;

    typedef enum logic [1:0] {
        ST_SET     = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_RUNNING = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [1:0] FLD_SEC = 2'd0;
    localparam logic [1:0] FLD_MIN = 2'd1;
    localparam logic [1:0] FLD_HR  = 2'd2;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    function automatic logic [1:0] next_field(input logic [1:0] field);
        case (field)
            FLD_SEC: next_field = FLD_MIN;
            FLD_MIN: next_field = FLD_HR;
            default: next_field = FLD_SEC;
        endcase
    endfunction

endpackage

// File: rtl/timer_controller_mod_counter.sv
// Modulo-(MAX+1) up/down counter with parallel load; borrow_out flags a 0->MAX decrement.
module mod_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             borrow_out
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

    // Simultaneous inc and dec cancel out, so only a lone dec can borrow.
    assign borrow_out = dec && !inc && !load && (value == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc && !dec) begin
            value <= (value == TOP) ? '0 : value + 1'b1;
        end else if (dec && !inc) begin
            value <= (value == '0) ? TOP : value - 1'b1;
        end
    end

endmodule

// File: rtl/timer_controller.sv
// Countdown timer: hh:mm:ss preset edited in SET, decremented once per second in RUNNING.
module timer_controller
    import timer_controller_pkg::*;
#(
    parameter int HR_MAX = 23
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       set_switch_i,
    input  logic       up_i,
    input  logic       down_reset_i,
    input  logic       setmode_runpause_i,
    input  logic       sec_tick_i,
    output logic [4:0] hours_o,
    output logic [5:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic [1:0] field_o,
    output logic       running_o,
    output logic       expired_o
);

    state_t     state;
    state_t     state_next;
    logic [1:0] field;
    logic       running;
    logic       expired;
    logic [4:0] preset_hr;
    logic [5:0] preset_min;
    logic [5:0] preset_sec;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       sec_borrow;
    logic       min_borrow;
    logic       hr_borrow;

    logic edit;
    logic edit_inc;
    logic edit_dec;
    logic reload;
    logic run_tick;
    logic live_zero;
    logic last_second;

    // Edits only apply once already in SET; the entry cycle ignores every key.
    assign edit        = (state == ST_SET) && set_switch_i && !setmode_runpause_i;
    assign edit_inc    = edit && up_i && !down_reset_i;
    assign edit_dec    = edit && down_reset_i && !up_i;
    assign reload      = !set_switch_i && (state != ST_SET) && down_reset_i;
    assign run_tick    = !set_switch_i && (state == ST_RUNNING) && sec_tick_i
                         && !down_reset_i && !setmode_runpause_i;
    assign live_zero   = (hr == 5'd0) && (min == 6'd0) && (sec == 6'd0);
    assign last_second = (hr == 5'd0) && (min == 6'd0) && (sec == 6'd1);

    mod_counter #(.WIDTH(6), .MAX(SEC_MAX)) u_sec (
        .clk        (clk_i),
        .rst_n      (nreset_i),
        .inc        (edit_inc && (field == FLD_SEC)),
        .dec        ((edit_dec && (field == FLD_SEC)) || run_tick),
        .load       (reload),
        .load_val   (preset_sec),
        .value      (sec),
        .borrow_out (sec_borrow)
    );

    mod_counter #(.WIDTH(6), .MAX(MIN_MAX)) u_min (
        .clk        (clk_i),
        .rst_n      (nreset_i),
        .inc        (edit_inc && (field == FLD_MIN)),
        .dec        ((edit_dec && (field == FLD_MIN)) || (run_tick && sec_borrow)),
        .load       (reload),
        .load_val   (preset_min),
        .value      (min),
        .borrow_out (min_borrow)
    );

    mod_counter #(.WIDTH(5), .MAX(HR_MAX)) u_hr (
        .clk        (clk_i),
        .rst_n      (nreset_i),
        .inc        (edit_inc && (field == FLD_HR)),
        .dec        ((edit_dec && (field == FLD_HR)) || (run_tick && min_borrow)),
        .load       (reload),
        .load_val   (preset_hr),
        .value      (hr),
        .borrow_out (hr_borrow)
    );

    // An hour borrow while running would mean the count wrapped past zero; treat it as expiry.
    always_comb begin
        state_next = state;
        if (set_switch_i) begin
            state_next = ST_SET;
        end else begin
            case (state)
                ST_SET:     state_next = ST_PAUSED;
                ST_PAUSED:  if (!down_reset_i && setmode_runpause_i && !live_zero)
                                state_next = ST_RUNNING;
                ST_RUNNING: if (down_reset_i || setmode_runpause_i)
                                state_next = ST_PAUSED;
                            else if (sec_tick_i && (last_second || hr_borrow))
                                state_next = ST_EXPIRED;
                ST_EXPIRED: if (down_reset_i || setmode_runpause_i)
                                state_next = ST_PAUSED;
                default:    state_next = ST_PAUSED;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state      <= ST_PAUSED;
            field      <= FLD_SEC;
            running    <= 1'b0;
            expired    <= 1'b0;
            preset_hr  <= '0;
            preset_min <= '0;
            preset_sec <= '0;
        end else begin
            state   <= state_next;
            running <= (state_next == ST_RUNNING);
            expired <= (state_next == ST_EXPIRED);
            if (set_switch_i && (state != ST_SET)) begin
                field <= FLD_SEC;
            end else if (set_switch_i && setmode_runpause_i) begin
                field <= next_field(field);
            end
            if ((state == ST_SET) && !set_switch_i) begin
                preset_hr  <= hr;
                preset_min <= min;
                preset_sec <= sec;
            end
        end
    end

    assign hours_o   = hr;
    assign minutes_o = min;
    assign seconds_o = sec;
    assign field_o   = field;
    assign running_o = running;
    assign expired_o = expired;

endmodule

// File: tb/tb_timer_controller.sv
// Directed scoreboard bench for the countdown-timer core.
module tb_timer_controller;

    logic       clk_i = 1'b0;
    logic       nreset_i;
    logic       set_switch_i;
    logic       up_i;
    logic       down_reset_i;
    logic       setmode_runpause_i;
    logic       sec_tick_i;
    logic [4:0] hours_o;
    logic [5:0] minutes_o;
    logic [5:0] seconds_o;
    logic [1:0] field_o;
    logic       running_o;
    logic       expired_o;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] f;
        logic       r;
        logic       e;
    } exp_t;

    exp_t sb[$];

    timer_controller #(.HR_MAX(23)) dut (
        .clk_i              (clk_i),
        .nreset_i           (nreset_i),
        .set_switch_i       (set_switch_i),
        .up_i               (up_i),
        .down_reset_i       (down_reset_i),
        .setmode_runpause_i (setmode_runpause_i),
        .sec_tick_i         (sec_tick_i),
        .hours_o            (hours_o),
        .minutes_o          (minutes_o),
        .seconds_o          (seconds_o),
        .field_o            (field_o),
        .running_o          (running_o),
        .expired_o          (expired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic push_exp(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s, input logic [1:0] f, input logic r, input logic e);
        exp_t x;
        x.tag = tag; x.h = h; x.m = m; x.s = s; x.f = f; x.r = r; x.e = e;
        sb.push_back(x);
    endtask

    task automatic compare_head();
        exp_t x;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            x = sb.pop_front();
            vectors++;
            assert ({hours_o, minutes_o, seconds_o, field_o, running_o, expired_o}
                    === {x.h, x.m, x.s, x.f, x.r, x.e})
            else begin
                miscompares++;
                $error("FAIL %s: got %0d:%0d:%0d fld=%0d run=%0b exp=%0b, want %0d:%0d:%0d fld=%0d run=%0b exp=%0b",
                       x.tag, hours_o, minutes_o, seconds_o, field_o, running_o, expired_o,
                       x.h, x.m, x.s, x.f, x.r, x.e);
            end
        end
    endtask

    // Drive one cycle of keys (sw is a level, the rest are one-cycle pulses) and check the result.
    task automatic step(input logic sw, input logic up, input logic dn, input logic rp, input logic tk,
                        input string tag, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                        input logic [1:0] f, input logic r, input logic e);
        set_switch_i       = sw;
        up_i               = up;
        down_reset_i       = dn;
        setmode_runpause_i = rp;
        sec_tick_i         = tk;
        push_exp(tag, h, m, s, f, r, e);
        @(posedge clk_i);
        #1;
        up_i               = 1'b0;
        down_reset_i       = 1'b0;
        setmode_runpause_i = 1'b0;
        sec_tick_i         = 1'b0;
        compare_head();
    endtask

    initial begin
        nreset_i           = 1'b0;
        set_switch_i       = 1'b0;
        up_i               = 1'b0;
        down_reset_i       = 1'b0;
        setmode_runpause_i = 1'b0;
        sec_tick_i         = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        push_exp("reset", 5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0);
        compare_head();
        nreset_i = 1'b1;

        // Edit to 23:02:00 and leave SET.
        step(1, 0, 0, 0, 0, "set_entry", 5'd0, 6'd0, 6'd0, 2'd0, 0, 0);
        step(1, 0, 0, 1, 0, "fld_min", 5'd0, 6'd0, 6'd0, 2'd1, 0, 0);
        step(1, 1, 0, 0, 0, "min_up1", 5'd0, 6'd1, 6'd0, 2'd1, 0, 0);
        step(1, 1, 0, 0, 0, "min_up2", 5'd0, 6'd2, 6'd0, 2'd1, 0, 0);
        step(1, 0, 0, 1, 0, "fld_hr", 5'd0, 6'd2, 6'd0, 2'd2, 0, 0);
        step(1, 0, 1, 0, 0, "hr_wrap_dn", 5'd23, 6'd2, 6'd0, 2'd2, 0, 0);
        step(0, 0, 0, 0, 0, "set_exit", 5'd23, 6'd2, 6'd0, 2'd2, 0, 0);

        // Preset 00:01:01, run three ticks, then reload.
        step(1, 0, 0, 0, 0, "set_entry2", 5'd23, 6'd2, 6'd0, 2'd0, 0, 0);
        step(1, 1, 0, 0, 0, "sec_up", 5'd23, 6'd2, 6'd1, 2'd0, 0, 0);
        step(1, 0, 0, 1, 0, "fld_min2", 5'd23, 6'd2, 6'd1, 2'd1, 0, 0);
        step(1, 0, 1, 0, 0, "min_dn", 5'd23, 6'd1, 6'd1, 2'd1, 0, 0);
        step(1, 0, 0, 1, 0, "fld_hr2", 5'd23, 6'd1, 6'd1, 2'd2, 0, 0);
        step(1, 1, 0, 0, 0, "hr_wrap_up", 5'd0, 6'd1, 6'd1, 2'd2, 0, 0);
        step(0, 0, 0, 0, 0, "set_exit2", 5'd0, 6'd1, 6'd1, 2'd2, 0, 0);
        step(0, 0, 0, 1, 0, "run", 5'd0, 6'd1, 6'd1, 2'd2, 1, 0);
        step(0, 0, 0, 0, 1, "tick1", 5'd0, 6'd1, 6'd0, 2'd2, 1, 0);
        step(0, 0, 0, 0, 1, "tick_borrow", 5'd0, 6'd0, 6'd59, 2'd2, 1, 0);
        step(0, 0, 0, 0, 1, "tick3", 5'd0, 6'd0, 6'd58, 2'd2, 1, 0);
        step(0, 0, 1, 0, 0, "run_reload", 5'd0, 6'd1, 6'd1, 2'd2, 0, 0);

        // Preset 00:00:02, expire, acknowledge, zero-count run refused.
        step(1, 0, 0, 0, 0, "set_entry3", 5'd0, 6'd1, 6'd1, 2'd0, 0, 0);
        step(1, 0, 0, 1, 0, "fld_min3", 5'd0, 6'd1, 6'd1, 2'd1, 0, 0);
        step(1, 0, 1, 0, 0, "min_dn3", 5'd0, 6'd0, 6'd1, 2'd1, 0, 0);
        step(1, 0, 0, 1, 0, "fld_hr3", 5'd0, 6'd0, 6'd1, 2'd2, 0, 0);
        step(1, 0, 0, 1, 0, "fld_wrap", 5'd0, 6'd0, 6'd1, 2'd0, 0, 0);
        step(1, 1, 0, 0, 0, "sec_up3", 5'd0, 6'd0, 6'd2, 2'd0, 0, 0);
        step(0, 0, 0, 0, 0, "set_exit3", 5'd0, 6'd0, 6'd2, 2'd0, 0, 0);
        step(0, 0, 0, 1, 0, "run3", 5'd0, 6'd0, 6'd2, 2'd0, 1, 0);
        step(0, 0, 0, 0, 1, "tick_a", 5'd0, 6'd0, 6'd1, 2'd0, 1, 0);
        step(0, 0, 0, 0, 1, "expire", 5'd0, 6'd0, 6'd0, 2'd0, 0, 1);
        step(0, 0, 0, 0, 1, "exp_tick_ign", 5'd0, 6'd0, 6'd0, 2'd0, 0, 1);
        step(0, 0, 0, 1, 0, "exp_ack", 5'd0, 6'd0, 6'd0, 2'd0, 0, 0);
        step(0, 0, 0, 1, 0, "zero_norun", 5'd0, 6'd0, 6'd0, 2'd0, 0, 0);
        step(0, 0, 1, 1, 0, "pause_reload", 5'd0, 6'd0, 6'd2, 2'd0, 0, 0);

        // Sec wraps, coincident keys, then preset 00:05:00.
        step(1, 0, 0, 0, 0, "set_entry4", 5'd0, 6'd0, 6'd2, 2'd0, 0, 0);
        step(1, 0, 1, 0, 0, "sec_dn_a", 5'd0, 6'd0, 6'd1, 2'd0, 0, 0);
        step(1, 0, 1, 0, 0, "sec_dn_b", 5'd0, 6'd0, 6'd0, 2'd0, 0, 0);
        step(1, 0, 1, 0, 0, "sec_wrap_dn", 5'd0, 6'd0, 6'd59, 2'd0, 0, 0);
        step(1, 1, 0, 0, 0, "sec_wrap_up", 5'd0, 6'd0, 6'd0, 2'd0, 0, 0);
        step(1, 0, 0, 1, 0, "fld_min4", 5'd0, 6'd0, 6'd0, 2'd1, 0, 0);
        for (int i = 1; i <= 5; i++)
            step(1, 1, 0, 0, 0, "min_up_loop", 5'd0, 6'(i), 6'd0, 2'd1, 0, 0);
        step(1, 1, 1, 0, 0, "up_dn_cancel", 5'd0, 6'd5, 6'd0, 2'd1, 0, 0);
        step(1, 1, 0, 1, 0, "setmode_wins", 5'd0, 6'd5, 6'd0, 2'd2, 0, 0);
        step(0, 0, 0, 0, 0, "set_exit4", 5'd0, 6'd5, 6'd0, 2'd2, 0, 0);
        step(0, 0, 0, 1, 0, "run4", 5'd0, 6'd5, 6'd0, 2'd2, 1, 0);
        step(0, 0, 1, 1, 1, "triple_key", 5'd0, 6'd5, 6'd0, 2'd2, 0, 0);
        step(0, 0, 0, 1, 0, "run4b", 5'd0, 6'd5, 6'd0, 2'd2, 1, 0);
        step(0, 0, 0, 0, 1, "tick4", 5'd0, 6'd4, 6'd59, 2'd2, 1, 0);
        step(0, 0, 0, 1, 1, "pause_drops_tick", 5'd0, 6'd4, 6'd59, 2'd2, 0, 0);
        step(0, 0, 1, 0, 0, "reload4", 5'd0, 6'd5, 6'd0, 2'd2, 0, 0);

        // Run from 00:03:10, then asynchronous reset mid-run.
        step(1, 0, 0, 0, 0, "set_entry5", 5'd0, 6'd5, 6'd0, 2'd0, 0, 0);
        step(1, 0, 0, 1, 0, "fld_min5", 5'd0, 6'd5, 6'd0, 2'd1, 0, 0);
        step(1, 0, 1, 0, 0, "min_dn5a", 5'd0, 6'd4, 6'd0, 2'd1, 0, 0);
        step(1, 0, 1, 0, 0, "min_dn5b", 5'd0, 6'd3, 6'd0, 2'd1, 0, 0);
        step(1, 0, 0, 1, 0, "fld_hr5", 5'd0, 6'd3, 6'd0, 2'd2, 0, 0);
        step(1, 0, 0, 1, 0, "fld_sec5", 5'd0, 6'd3, 6'd0, 2'd0, 0, 0);
        for (int i = 1; i <= 10; i++)
            step(1, 1, 0, 0, 0, "sec_up_loop", 5'd0, 6'd3, 6'(i), 2'd0, 0, 0);
        step(0, 0, 0, 0, 0, "set_exit5", 5'd0, 6'd3, 6'd10, 2'd0, 0, 0);
        step(0, 0, 0, 1, 0, "run5", 5'd0, 6'd3, 6'd10, 2'd0, 1, 0);
        step(0, 0, 0, 0, 1, "tick5", 5'd0, 6'd3, 6'd9, 2'd0, 1, 0);
        #2;
        nreset_i = 1'b0;
        #1;
        push_exp("async_reset", 5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0);
        compare_head();
        @(posedge clk_i);
        #1;
        push_exp("reset_held", 5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0);
        compare_head();
        nreset_i = 1'b1;
        step(0, 0, 0, 1, 0, "post_rst_norun", 5'd0, 6'd0, 6'd0, 2'd0, 0, 0);
        step(0, 0, 1, 0, 0, "preset_lost", 5'd0, 6'd0, 6'd0, 2'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
